// File: rtl/udp_rx_pkt_buffer_pkg.sv
// Shared definitions for the UDP receive packet buffer.
package udp_rx_pkg;

  // Read-side sequencer states
  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FETCH,
    RD_STREAM
  } rd_state_t;

  // Headroom below which the receiver is told to stop sending
  localparam int OVF_MARGIN = 16;

  // Width of packet lengths and byte counters
  localparam int LEN_W = 16;

endpackage

// File: rtl/udp_rx_pkt_buffer_if.sv
// Byte-stream bundle between receiver, buffer and payload consumer.
interface udp_rx_pkt_buffer_if;
  import udp_rx_pkg::*;

  logic             in_valid;
  logic [7:0]       in_data;
  logic [LEN_W-1:0] in_len;
  logic             in_done;
  logic             in_err;
  logic             overflow_o;
  logic             out_valid;
  logic [7:0]       out_data;
  logic             out_last;
  logic [LEN_W-1:0] out_len;
  logic             out_ready;

  // Buffer side
  modport slave (
    input  in_valid, in_data, in_len, in_done, in_err, out_ready,
    output overflow_o, out_valid, out_data, out_last, out_len
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_data, in_len, in_done, in_err, out_ready,
    input  overflow_o, out_valid, out_data, out_last, out_len
  );
endinterface

// File: rtl/udp_rx_pkt_buffer_ram.sv
// Simple dual-port payload RAM: one write port, one read port with a
// registered, enable-gated output so a fetched byte stays put until the
// next read is issued.
module udp_rxbuf_ram #(
  parameter int ADDR_W = 11
) (
  input  logic              clk_125m,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);
  logic [7:0] mem [0:(2**ADDR_W)-1];

  // Write port
  always_ff @(posedge clk_125m) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port, held when no read is issued
  always_ff @(posedge clk_125m) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/udp_rx_pkt_buffer.sv
// Packet-granular UDP payload buffer. Bytes land in RAM speculatively and
// become visible to the reader only when the packet commits; bad packets
// are rewound to the last commit point.
// Optional build macro: UDP_RXBUF_STATS_EN adds commit/rollback counters.
module udp_rx_pkt_buffer
  import udp_rx_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int LEN_AW = 2
) (
  input  logic clk_125m,
  input  logic rst,
  udp_rx_pkt_buffer_if.slave bus
`ifdef UDP_RXBUF_STATS_EN
  ,
  output logic [LEN_W-1:0] stat_pkt_ok,
  output logic [LEN_W-1:0] stat_pkt_drop
`endif
);
  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH = PW'(2**ADDR_W);

  // Write-side state
  logic [PW-1:0]    wr_ptr_reg, wr_commit_reg, rd_ptr_reg;
  logic [LEN_W-1:0] wcnt_reg;
  logic             drop_reg;
  logic [PW-1:0]    used, free, wr_ptr_inc;
  logic [LEN_W-1:0] wcnt_inc;
  logic             full, byte_ok, drop_eff, commit, rollback;

  // Length FIFO
  logic [LEN_W-1:0] lf_mem [0:(2**LEN_AW)-1];
  logic [LEN_AW:0]  lf_wr_reg, lf_rd_reg;
  logic             lf_empty, lf_full, lf_pop;
  logic [LEN_W-1:0] lf_head;

  // Read side
  rd_state_t         state_reg, state_next;
  logic [LEN_W-1:0]  out_len_reg, rcnt_reg, fcnt_reg;
  logic [ADDR_W-1:0] fetch_ptr_reg;
  logic              hold_valid_reg, dout_valid_reg;
  logic [7:0]        hold_data_reg, ram_dout;
  logic              out_valid, pop, issue, hold_keep, dout_keep;
  logic              overflow_reg;

  assign used       = wr_ptr_reg - rd_ptr_reg;
  assign free       = DEPTH - used;
  assign full       = (used == DEPTH);
  assign byte_ok    = bus.in_valid & ~full;
  assign wr_ptr_inc = wr_ptr_reg + PW'(byte_ok);
  assign wcnt_inc   = wcnt_reg + LEN_W'(byte_ok);
  assign drop_eff   = drop_reg | (bus.in_valid & full);

  assign lf_empty = (lf_wr_reg == lf_rd_reg);
  assign lf_full  = (lf_wr_reg == {~lf_rd_reg[LEN_AW], lf_rd_reg[LEN_AW-1:0]});
  assign lf_head  = lf_mem[lf_rd_reg[LEN_AW-1:0]];

  // A byte arriving with in_done is already included in wcnt_inc
  assign commit   = bus.in_done & ~bus.in_err & ~drop_eff & (wcnt_inc != '0) &
                    (wcnt_inc == bus.in_len) & ~lf_full;
  assign rollback = (bus.in_done | bus.in_err) & ~commit;

  udp_rxbuf_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk_125m (clk_125m),
    .rst      (rst),
    .wr_en    (byte_ok),
    .wr_addr  (wr_ptr_reg[ADDR_W-1:0]),
    .wr_data  (bus.in_data),
    .rd_en    (issue),
    .rd_addr  (fetch_ptr_reg),
    .rd_data  (ram_dout)
  );

  // Write pointer, byte count and drop flag; commit or rewind at packet end
  always_ff @(posedge clk_125m) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      wr_commit_reg <= '0;
      wcnt_reg      <= '0;
      drop_reg      <= 1'b0;
    end else if (commit) begin
      wr_ptr_reg    <= wr_ptr_inc;
      wr_commit_reg <= wr_ptr_inc;
      wcnt_reg      <= '0;
      drop_reg      <= 1'b0;
    end else if (rollback) begin
      wr_ptr_reg    <= wr_commit_reg;
      wcnt_reg      <= '0;
      drop_reg      <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_inc;
      wcnt_reg      <= wcnt_inc;
      drop_reg      <= drop_eff;
    end
  end

  // Length FIFO storage
  always_ff @(posedge clk_125m) begin
    if (commit) lf_mem[lf_wr_reg[LEN_AW-1:0]] <= wcnt_inc;
  end

  // Length FIFO pointers
  always_ff @(posedge clk_125m) begin
    if (rst) begin
      lf_wr_reg <= '0;
      lf_rd_reg <= '0;
    end else begin
      if (commit) lf_wr_reg <= lf_wr_reg + 1'b1;
      if (lf_pop) lf_rd_reg <= lf_rd_reg + 1'b1;
    end
  end

  // Output queue is the hold register (front) plus the RAM output (back).
  // A new read may only be issued if the hold slot is free after this pop.
  assign out_valid = hold_valid_reg | dout_valid_reg;
  assign pop       = out_valid & bus.out_ready;
  assign lf_pop    = (state_reg == RD_IDLE) & ~lf_empty;
  assign issue     = ((state_reg == RD_FETCH) || (state_reg == RD_STREAM)) &&
                     (fcnt_reg != '0) && (!hold_valid_reg || pop);
  assign hold_keep = hold_valid_reg & ~pop;
  assign dout_keep = dout_valid_reg & ~(pop & ~hold_valid_reg);

  // Read FSM state register
  always_ff @(posedge clk_125m) begin
    if (rst) state_reg <= RD_IDLE;
    else     state_reg <= state_next;
  end

  // Read FSM next-state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RD_IDLE:   if (!lf_empty) state_next = RD_FETCH;
      RD_FETCH:  state_next = RD_STREAM;
      RD_STREAM: if (pop && rcnt_reg == LEN_W'(1)) state_next = RD_IDLE;
      default:   state_next = RD_IDLE;
    endcase
  end

  // Read pointers, counters and output queue
  always_ff @(posedge clk_125m) begin
    if (rst) begin
      out_len_reg    <= '0;
      rcnt_reg       <= '0;
      fcnt_reg       <= '0;
      rd_ptr_reg     <= '0;
      fetch_ptr_reg  <= '0;
      hold_valid_reg <= 1'b0;
      hold_data_reg  <= '0;
      dout_valid_reg <= 1'b0;
    end else begin
      if (lf_pop) begin
        out_len_reg <= lf_head;
        rcnt_reg    <= lf_head;
        fcnt_reg    <= lf_head;
      end else begin
        if (pop)   rcnt_reg <= rcnt_reg - 1'b1;
        if (issue) fcnt_reg <= fcnt_reg - 1'b1;
      end
      if (pop)   rd_ptr_reg    <= rd_ptr_reg + 1'b1;
      if (issue) fetch_ptr_reg <= fetch_ptr_reg + 1'b1;
      if (issue) begin
        hold_valid_reg <= dout_keep;
        if (dout_keep) hold_data_reg <= ram_dout;
        dout_valid_reg <= 1'b1;
      end else begin
        hold_valid_reg <= hold_keep;
        dout_valid_reg <= dout_keep;
      end
    end
  end

  // Flow-control hint back to the receiver
  always_ff @(posedge clk_125m) begin
    if (rst) overflow_reg <= 1'b0;
    else     overflow_reg <= (free < PW'(OVF_MARGIN)) | lf_full;
  end

  assign bus.overflow_o = overflow_reg;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = hold_valid_reg ? hold_data_reg : ram_dout;
  assign bus.out_last   = out_valid & (rcnt_reg == LEN_W'(1));
  assign bus.out_len    = out_len_reg;

`ifdef UDP_RXBUF_STATS_EN
  // Saturating packet outcome counters
  always_ff @(posedge clk_125m) begin
    if (rst) begin
      stat_pkt_ok   <= '0;
      stat_pkt_drop <= '0;
    end else begin
      if (commit && stat_pkt_ok != '1)     stat_pkt_ok   <= stat_pkt_ok + LEN_W'(1);
      if (rollback && stat_pkt_drop != '1) stat_pkt_drop <= stat_pkt_drop + LEN_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_udp_rx_pkt_buffer.sv
// Directed bench for udp_rx_pkt_buffer: table of packets plus hand-written
// backpressure, back-to-back, reset and overflow sequences.
module tb_udp_rx_pkt_buffer;
  import udp_rx_pkg::*;

  logic clk = 1'b0;
  always #4 clk = ~clk;

  logic rst;
  int   sel;
  int   errors = 0;
  int   checks = 0;

  logic        t_valid, t_done, t_err, t_ready;
  logic [7:0]  t_data;
  logic [15:0] t_len;

  udp_rx_pkt_buffer_if bus ();
  udp_rx_pkt_buffer_if bus2 ();

  assign bus.in_valid   = t_valid & (sel == 0);
  assign bus.in_done    = t_done  & (sel == 0);
  assign bus.in_err     = t_err   & (sel == 0);
  assign bus.out_ready  = t_ready & (sel == 0);
  assign bus.in_data    = t_data;
  assign bus.in_len     = t_len;
  assign bus2.in_valid  = t_valid & (sel == 1);
  assign bus2.in_done   = t_done  & (sel == 1);
  assign bus2.in_err    = t_err   & (sel == 1);
  assign bus2.out_ready = t_ready & (sel == 1);
  assign bus2.in_data   = t_data;
  assign bus2.in_len    = t_len;

  logic        o_valid, o_last, o_ovf;
  logic [7:0]  o_data;
  logic [15:0] o_len;
  assign o_valid = (sel == 1) ? bus2.out_valid  : bus.out_valid;
  assign o_last  = (sel == 1) ? bus2.out_last   : bus.out_last;
  assign o_ovf   = (sel == 1) ? bus2.overflow_o : bus.overflow_o;
  assign o_data  = (sel == 1) ? bus2.out_data   : bus.out_data;
  assign o_len   = (sel == 1) ? bus2.out_len    : bus.out_len;

`ifdef UDP_RXBUF_STATS_EN
  logic [15:0] ok1, dr1, ok2, dr2;
`endif

  udp_rx_pkt_buffer #(.ADDR_W(11), .LEN_AW(2)) dut (
    .clk_125m (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef UDP_RXBUF_STATS_EN
    ,
    .stat_pkt_ok   (ok1),
    .stat_pkt_drop (dr1)
`endif
  );

  udp_rx_pkt_buffer #(.ADDR_W(6), .LEN_AW(2)) dut2 (
    .clk_125m (clk),
    .rst      (rst),
    .bus      (bus2)
`ifdef UDP_RXBUF_STATS_EN
    ,
    .stat_pkt_ok   (ok2),
    .stat_pkt_drop (dr2)
`endif
  );

  typedef struct {
    int nbytes;
    int base;
    int in_len;
    bit err;
    bit same;
    bit deliver;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive n payload bytes then in_done (optionally on the same cycle as the last byte)
  task automatic send_pkt(input int n, input int base, input int len, input bit err, input bit same);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      t_valid = 1'b1;
      t_data  = 8'(base + i);
      t_done  = 1'b0;
      t_err   = 1'b0;
      if (same && i == n - 1) begin
        t_done = 1'b1;
        t_err  = err;
        t_len  = 16'(len);
      end
    end
    if (!same || n == 0) begin
      @(negedge clk);
      t_valid = 1'b0;
      t_done  = 1'b1;
      t_err   = err;
      t_len   = 16'(len);
    end
  endtask

  // Count negedges until out_valid shows up
  task automatic await_out(input int budget, output bit found, output int lat);
    found = 1'b0;
    lat   = 0;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      t_valid = 1'b0;
      t_done  = 1'b0;
      t_err   = 1'b0;
      t_ready = 1'b0;
      if (o_valid) begin
        found = 1'b1;
        lat   = c;
        break;
      end
    end
  endtask

  // Read a packet; mode 0 always ready, mode 1 ready pattern 1,0,0,...
  task automatic collect(input int exp_len, input int base, input int mode, input int stop_after);
    int         idx  = 0;
    int         cyc  = 0;
    bit         held = 1'b0;
    logic [7:0] hd;
    logic       hl;
    logic [15:0] hn;
    logic       rdy;
    logic [7:0] eb;
    while (idx < stop_after && cyc < 4000) begin
      if (idx > 0 || held) check("valid_held", int'(o_valid), 1);
      if (held) begin
        check("stall_data", int'(o_data), int'(hd));
        check("stall_last", int'(o_last), int'(hl));
        check("stall_len", int'(o_len), int'(hn));
      end
      rdy = (mode == 0) || (cyc % 3 == 0);
      t_ready = rdy;
      if (o_valid && rdy) begin
        eb = 8'(base + idx);
        check("data", int'(o_data), int'(eb));
        check("last", int'(o_last), (idx == exp_len - 1) ? 1 : 0);
        check("len", int'(o_len), exp_len);
        idx++;
        held = 1'b0;
      end else if (o_valid) begin
        held = 1'b1;
        hd   = o_data;
        hl   = o_last;
        hn   = o_len;
      end
      cyc++;
      @(negedge clk);
    end
    t_ready = 1'b0;
    if (stop_after == exp_len) begin
      check("byte_count", idx, exp_len);
      check("valid_after_last", int'(o_valid), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int lat;
    int committed;
    int exp_ok;
    int exp_drop;
    bit exp_ov;
    int u;

    vecs[0] = '{100, 1,    100, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{10,  50,   10,  1'b1, 1'b0, 1'b0};
    vecs[2] = '{10,  200,  10,  1'b0, 1'b0, 1'b1};
    vecs[3] = '{20,  7,    21,  1'b0, 1'b0, 1'b0};
    vecs[4] = '{1,   8'hAA, 1,  1'b0, 1'b0, 1'b1};
    vecs[5] = '{0,   0,    0,   1'b0, 1'b0, 1'b0};
    vecs[6] = '{6,   8'h60, 6,  1'b0, 1'b1, 1'b1};
    vecs[7] = '{6,   8'h70, 5,  1'b0, 1'b0, 1'b0};
    vecs[8] = '{4,   8'h80, 4,  1'b1, 1'b1, 1'b0};

    sel = 0; rst = 1'b1;
    t_valid = 1'b0; t_done = 1'b0; t_err = 1'b0; t_ready = 1'b0;
    t_data = '0; t_len = '0;
    committed = 0; exp_ok = 0; exp_drop = 0;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(o_valid), 0);
    check("rst_last", int'(o_last), 0);
    check("rst_ovf", int'(o_ovf), 0);
    check("rst_data", int'(o_data), 0);
    check("rst_len", int'(o_len), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 9; k++) begin
      send_pkt(vecs[k].nbytes, vecs[k].base, vecs[k].in_len, vecs[k].err, vecs[k].same);
      await_out(vecs[k].deliver ? 12 : 10, found, lat);
      if (vecs[k].deliver) begin
        check($sformatf("v%0d_latency", k), lat, 3);
        collect(vecs[k].in_len, vecs[k].base, 0, vecs[k].in_len);
        committed += vecs[k].in_len;
        exp_ok++;
      end else begin
        check($sformatf("v%0d_no_output", k), int'(found), 0);
        exp_drop++;
      end
      check($sformatf("v%0d_wr_ptr", k), int'(dut.wr_ptr_reg), committed % 4096);
    end

    // in_err alone mid-packet rewinds; the following packet stands alone
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      t_valid = 1'b1; t_data = 8'(8'h90 + i);
    end
    @(negedge clk);
    t_valid = 1'b0; t_err = 1'b1;
    send_pkt(3, 8'hA0, 3, 1'b0, 1'b0);
    await_out(12, found, lat);
    check("solo_err_latency", lat, 3);
    collect(3, 8'hA0, 0, 3);
    committed += 3; exp_ok++; exp_drop++;

    // Backpressure 1,0,0,1,...
    send_pkt(10, 8'h20, 10, 1'b0, 1'b0);
    await_out(12, found, lat);
    check("bp_latency", lat, 3);
    collect(10, 8'h20, 1, 10);
    committed += 10; exp_ok++;

    // Back-to-back: second packet follows after IDLE and FETCH
    send_pkt(5, 8'h40, 5, 1'b0, 1'b0);
    send_pkt(5, 8'h50, 5, 1'b0, 1'b0);
    await_out(12, found, lat);
    check("b2b_first_found", int'(found), 1);
    collect(5, 8'h40, 0, 5);
    await_out(12, found, lat);
    check("b2b_gap", lat, 2);
    collect(5, 8'h50, 0, 5);
    committed += 10; exp_ok += 2;

`ifdef UDP_RXBUF_STATS_EN
    check("stat_ok", int'(ok1), exp_ok);
    check("stat_drop", int'(dr1), exp_drop);
`endif

    // Reset after 5 of 100 bytes have been read
    send_pkt(100, 1, 100, 1'b0, 1'b0);
    await_out(12, found, lat);
    check("rst_pkt_latency", lat, 3);
    collect(100, 1, 0, 5);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", int'(o_valid), 0);
    check("midrst_len", int'(o_len), 0);
    check("midrst_ovf", int'(o_ovf), 0);
    rst = 1'b0;
    send_pkt(4, 8'h30, 4, 1'b0, 1'b0);
    await_out(12, found, lat);
    check("post_rst_latency", lat, 3);
    collect(4, 8'h30, 0, 4);
    check("post_rst_wr_ptr", int'(dut.wr_ptr_reg), 4);

    // Overflow on the 64-byte instance: overflow_o lags occupancy by one cycle
    sel = 1;
    for (int j = 0; j <= 80; j++) begin
      @(negedge clk);
      u = (j >= 1) ? ((j - 1 > 64) ? 64 : j - 1) : 0;
      exp_ov = (u >= 49);
      check($sformatf("ovf_j%0d", j), int'(o_ovf), int'(exp_ov));
      if (j < 80) begin
        t_valid = 1'b1; t_data = 8'(j); t_done = 1'b0;
      end else begin
        t_valid = 1'b0; t_done = 1'b1; t_len = 16'd80;
      end
    end
    await_out(10, found, lat);
    check("ovf_no_output", int'(found), 0);
    check("ovf_released", int'(o_ovf), 0);
    send_pkt(8, 8'hC0, 8, 1'b0, 1'b0);
    await_out(12, found, lat);
    check("ovf_next_latency", lat, 3);
    collect(8, 8'hC0, 0, 8);
`ifdef UDP_RXBUF_STATS_EN
    check("stat2_ok", int'(ok2), 1);
    check("stat2_drop", int'(dr2), 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
